mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have the ports listed below; clock and reset SHALL be: clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-002 The input ports SHALL be:
- stall  input  1  hold all registers
- flush  input  1  load a bubble
- m_valid  input  1  MEM slot holds a real instruction
- m_pc  input  32  instruction PC
- m_load_op  input  3  000 none, 001 lw, 010 lb, 011 lbu, 100 lh, 101 lhu; 110 and 111 reserved, treated as none
- m_addr_lo  input  2  data address bits [1:0]
- m_dm_rdata  input  32  word read from data memory at the word address
- m_alu  input  32  ALU result
- m_pc8  input  32  link value (PC+8)
- m_wb_sel  input  2  00 ALU, 01 load, 10 link; 11 reserved, treated as ALU
- m_we  input  1  register write request
- m_rd  input  5  destination register
REQ-003 The output ports SHALL be:
- w_valid  output  1  WB slot valid
- w_pc  output  32  WB PC
- w_we  output  1  GRF write enable
- w_rd  output  5  GRF write address
- w_data  output  32  GRF write data
- w_misalign  output  1  faulting load in WB
- retire_cnt  output  32  valid instructions retired

Function
REQ-004 The block SHALL be a single-stage register; every output SHALL be a flop output, with no input-to-output combinational path, and latency SHALL be 1 cycle.
REQ-005 Update priority per rising clk SHALL be reset > flush > stall > capture.
REQ-006 On flush, w_valid, w_we, w_misalign, w_rd, w_data and w_pc SHALL all be 0.
REQ-007 On stall (no flush), all WB registers and retire_cnt SHALL hold.
REQ-008 Byte select for lb/lbu SHALL use m_dm_rdata[8*k+7:8*k] with k=m_addr_lo; lb SHALL sign-extend and lbu SHALL zero-extend.
REQ-009 Halfword select for lh/lhu SHALL be m_dm_rdata[15:0] when m_addr_lo[1]=0 and m_dm_rdata[31:16] otherwise; lh SHALL sign-extend and lhu SHALL zero-extend.
REQ-010 lw SHALL pass m_dm_rdata unchanged.
REQ-011 Misalignment SHALL be: lw with m_addr_lo!=00, or lh/lhu with m_addr_lo[0]=1.
REQ-012 On capture of a misaligned load, w_misalign SHALL be 1, w_we SHALL be 0, and w_data SHALL be 0.
REQ-013 A load op with m_wb_sel!=01 SHALL NOT be flagged misaligned, and its data SHALL NOT be used.
REQ-014 w_data SHALL be selected by m_wb_sel: ALU, extended load, or link.
REQ-015 w_we on capture SHALL be m_valid AND m_we AND (m_rd!=0) AND NOT misaligned.
REQ-016 When m_valid=0, capture SHALL store w_valid=0, w_we=0, w_misalign=0; w_pc, w_rd and w_data SHALL still load from the inputs.
REQ-017 retire_cnt SHALL increment by 1 on each capture edge with m_valid=1, and SHALL wrap from FFFFFFFF to 0.
REQ-018 retire_cnt SHALL NOT change on flush, stall or reset-free bubble cycles.
REQ-019 Simulation: on each capture edge where w_we is set, the block SHALL print "%d@%h: $%d <= %h" with time, m_pc, m_rd and the write data (same format as the DM store log).
REQ-020 Simulation: nothing SHALL be printed for rd=0, stall, flush or misalign.

Reset
REQ-021 While reset=1 at a clk edge, all outputs SHALL be 0, including retire_cnt; reset SHALL override stall and flush.
REQ-022 A reset asserted mid-pipeline SHALL discard the captured instruction without logging.
REQ-023 All registers SHALL also initialise to 0 at time 0.

Verification
REQ-024 m_dm_rdata=8badf00d, lb, addr_lo=01, rd=5, valid, we -> next cycle w_data=fffffff0, w_we=1, w_rd=5, log printed.
REQ-025 Same data, lhu, addr_lo=10 -> w_data=00008bad; lh, addr_lo=11 -> w_misalign=1, w_we=0, w_data=0.
REQ-026 jal with wb_sel=10, m_pc8=00003008, rd=31 -> w_data=00003008; then rd=0 with we=1 -> w_we=0, no log, retire_cnt still +1.
REQ-027 stall and flush both high with a valid input -> outputs zero, retire_cnt unchanged; stall alone for 3 cycles -> outputs and count held.
REQ-028 Preload retire_cnt to FFFFFFFF via 2^32 captures, or a forced value in the bench; one more valid capture -> 00000000.
REQ-029 Reset asserted together with stall=1 after 10 retirements -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage signal bundle: stage controls and MEM-slot fields in, WB-slot fields out.
// The master side drives the MEM slot; the slave side is the stage register.
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [2:0]  m_load_op;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_dm_rdata;
  logic [31:0] m_alu;
  logic [31:0] m_pc8;
  logic [1:0]  m_wb_sel;
  logic        m_we;
  logic [4:0]  m_rd;

  logic        w_valid;
  logic [31:0] w_pc;
  logic        w_we;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        w_misalign;
  logic [31:0] retire_cnt;

  modport master (
    output stall, flush, m_valid, m_pc, m_load_op, m_addr_lo, m_dm_rdata,
           m_alu, m_pc8, m_wb_sel, m_we, m_rd,
    input  w_valid, w_pc, w_we, w_rd, w_data, w_misalign, retire_cnt
  );

  modport slave (
    input  stall, flush, m_valid, m_pc, m_load_op, m_addr_lo, m_dm_rdata,
           m_alu, m_pc8, m_wb_sel, m_we, m_rd,
    output w_valid, w_pc, w_we, w_rd, w_data, w_misalign, retire_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction/extension, misalignment check,
// write-back mux and retired-instruction counter. All outputs are flops.
module mem_wb_stage (
  input  logic           clk,
  input  logic           reset,
  mem_wb_stage_if.slave  bus
);

  logic        valid_q    = 1'b0;
  logic [31:0] pc_q       = '0;
  logic        we_q       = 1'b0;
  logic [4:0]  rd_q       = '0;
  logic [31:0] data_q     = '0;
  logic        misalign_q = 1'b0;
  logic [31:0] cnt_q      = '0;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic        load_bad;
  logic        misaligned;
  logic [31:0] data_d;
  logic        we_d;

  always_comb begin
    byte_sel = bus.m_dm_rdata[7:0];
    case (bus.m_addr_lo)
      2'd1:    byte_sel = bus.m_dm_rdata[15:8];
      2'd2:    byte_sel = bus.m_dm_rdata[23:16];
      2'd3:    byte_sel = bus.m_dm_rdata[31:24];
      default: byte_sel = bus.m_dm_rdata[7:0];
    endcase
    half_sel = bus.m_addr_lo[1] ? bus.m_dm_rdata[31:16] : bus.m_dm_rdata[15:0];
  end

  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    case (bus.m_load_op)
      3'b001: begin
        load_val = bus.m_dm_rdata;
        load_bad = (bus.m_addr_lo != 2'b00);
      end
      3'b010: load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b011: load_val = {24'h0, byte_sel};
      3'b100: begin
        load_val = {{16{half_sel[15]}}, half_sel};
        load_bad = bus.m_addr_lo[0];
      end
      3'b101: begin
        load_val = {16'h0, half_sel};
        load_bad = bus.m_addr_lo[0];
      end
      default: begin
        load_val = '0;
        load_bad = 1'b0;
      end
    endcase
  end

  // A load only matters when write-back actually selects it.
  assign misaligned = (bus.m_wb_sel == 2'b01) && load_bad;

  always_comb begin
    case (bus.m_wb_sel)
      2'b01:   data_d = misaligned ? 32'h0 : load_val;
      2'b10:   data_d = bus.m_pc8;
      default: data_d = bus.m_alu;
    endcase
  end

  assign we_d = bus.m_valid && bus.m_we && (bus.m_rd != 5'd0) && !misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q    <= bus.m_valid;
      pc_q       <= bus.m_pc;
      we_q       <= we_d;
      rd_q       <= bus.m_rd;
      data_q     <= data_d;
      misalign_q <= bus.m_valid && misaligned;
      if (bus.m_valid) cnt_q <= cnt_q + 32'd1;
`ifndef SYNTHESIS
      // Same line format as the data-memory store log.
      if (we_d) $display("%d@%h: $%d <= %h", $time, bus.m_pc, bus.m_rd, data_d);
`endif
    end
  end

  assign bus.w_valid    = valid_q;
  assign bus.w_pc       = pc_q;
  assign bus.w_we       = we_q;
  assign bus.w_rd       = rd_q;
  assign bus.w_data     = data_q;
  assign bus.w_misalign = misalign_q;
  assign bus.retire_cnt = cnt_q;

endmodule
